memory_access_stage: RTL and testbench

// - Consumer end of the execute->memwrite pipeline bundle: takes RegWriteM, ResultSrcM, MemWriteM, MemoryOpM,

---
 rtl/memory_access_stage.sv | 182 ++++++++++++++++++
 tb/tb_memory_access_stage.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/memory_access_stage.sv
// Memory-access pipeline stage: req/ack data-memory port, store lane alignment, load extension, MEM/WB register.
// Optional misaligned-access trap enabled by defining MISALIGN_TRAP_EN (adds MisalignW output).
module memory_access_stage #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  RegWriteM,
  input  logic [1:0]            ResultSrcM,
  input  logic                  MemWriteM,
  input  logic [2:0]            MemoryOpM,
  input  logic [DATA_WIDTH-1:0] ALUResultM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  input  logic [ADDR_WIDTH-1:0] RdM,
  input  logic [DATA_WIDTH-1:0] PCPlus4M,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  StallM,
`ifdef MISALIGN_TRAP_EN
  output logic                  MisalignW,
`endif
  output logic                  RegWriteW,
  output logic [1:0]            ResultSrcW,
  output logic [DATA_WIDTH-1:0] ALUResultW,
  output logic [DATA_WIDTH-1:0] ReadDataW,
  output logic [ADDR_WIDTH-1:0] RdW,
  output logic [DATA_WIDTH-1:0] PCPlus4W
);

  localparam int unsigned STRB_W = 4;
  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  state_e state_q, state_d;

  logic                  is_load;
  logic                  access;
  logic                  misalign;
  logic                  go;
  logic [1:0]            byte_off;
  logic [7:0]            rd_byte;
  logic [15:0]           rd_half;
  logic [DATA_WIDTH-1:0] load_data;

  assign is_load  = (ResultSrcM == 2'b01);
  assign access   = MemWriteM | is_load;
  assign byte_off = ALUResultM[1:0];

`ifdef MISALIGN_TRAP_EN
  always_comb begin
    misalign = 1'b0;
    if (access) begin
      case (MemoryOpM)
        OP_H, OP_HU: misalign = byte_off[0];
        OP_W:        misalign = (byte_off != 2'b00);
        default:     misalign = 1'b0;
      endcase
    end
  end
`else
  assign misalign = 1'b0;
`endif

  assign go = access & ~misalign;

  // Store lane steering: halfwords always land on an even lane pair
  assign mem_we   = MemWriteM;
  assign mem_addr = {ALUResultM[DATA_WIDTH-1:2], 2'b00};

  always_comb begin
    mem_wstrb = '0;
    mem_wdata = '0;
    if (MemWriteM) begin
      case (MemoryOpM)
        OP_B: begin
          mem_wstrb = STRB_W'(4'b0001 << byte_off);
          mem_wdata = {4{WriteDataM[7:0]}};
        end
        OP_H: begin
          mem_wstrb = byte_off[1] ? 4'b1100 : 4'b0011;
          mem_wdata = {2{WriteDataM[15:0]}};
        end
        default: begin
          mem_wstrb = 4'b1111;
          mem_wdata = WriteDataM;
        end
      endcase
    end
  end

  // Load extraction from the aligned read word
  always_comb begin
    case (byte_off)
      2'd0:    rd_byte = mem_rdata[7:0];
      2'd1:    rd_byte = mem_rdata[15:8];
      2'd2:    rd_byte = mem_rdata[23:16];
      default: rd_byte = mem_rdata[31:24];
    endcase
    rd_half = byte_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  end

  always_comb begin
    load_data = '0;
    if (is_load && !misalign) begin
      case (MemoryOpM)
        OP_B:    load_data = {{24{rd_byte[7]}}, rd_byte};
        OP_BU:   load_data = {24'd0, rd_byte};
        OP_H:    load_data = {{16{rd_half[15]}}, rd_half};
        OP_HU:   load_data = {16'd0, rd_half};
        default: load_data = mem_rdata;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Request/stall are forced low while reset is asserted so an abort is visible immediately
  always_comb begin
    state_d = state_q;
    mem_req = 1'b0;
    StallM  = 1'b0;
    case (state_q)
      S_IDLE: begin
        mem_req = rst_n & go;
        StallM  = rst_n & go & ~mem_ack;
        if (go && !mem_ack) state_d = S_WAIT;
      end
      S_WAIT: begin
        mem_req = rst_n;
        StallM  = rst_n & ~mem_ack;
        if (mem_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // MEM/WB register; a stalled cycle becomes a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= 2'b00;
      ALUResultW <= '0;
      ReadDataW  <= '0;
      RdW        <= '0;
      PCPlus4W   <= '0;
`ifdef MISALIGN_TRAP_EN
      MisalignW  <= 1'b0;
`endif
    end else if (StallM) begin
      RegWriteW  <= 1'b0;
      RdW        <= '0;
`ifdef MISALIGN_TRAP_EN
      MisalignW  <= 1'b0;
`endif
    end else begin
      RegWriteW  <= RegWriteM & ~misalign;
      ResultSrcW <= ResultSrcM;
      ALUResultW <= ALUResultM;
      ReadDataW  <= load_data;
      RdW        <= RdM;
      PCPlus4W   <= PCPlus4M;
`ifdef MISALIGN_TRAP_EN
      MisalignW  <= misalign;
`endif
    end
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// Randomized bench for memory_access_stage against a behavioural reference model.
module tb_memory_access_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        RegWriteM;
  logic [1:0]  ResultSrcM;
  logic        MemWriteM;
  logic [2:0]  MemoryOpM;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RdM;
  logic        mem_req, mem_we, mem_ack, StallM;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
  logic [4:0]  RdW;
`ifdef MISALIGN_TRAP_EN
  logic        MisalignW;
`endif

  always #5 clk = ~clk;

  memory_access_stage dut (
    .clk(clk), .rst_n(rst_n),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM), .MemoryOpM(MemoryOpM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .RdM(RdM), .PCPlus4M(PCPlus4M),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .StallM(StallM),
`ifdef MISALIGN_TRAP_EN
    .MisalignW(MisalignW),
`endif
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .ALUResultW(ALUResultW),
    .ReadDataW(ReadDataW), .RdW(RdW), .PCPlus4W(PCPlus4W)
  );

  int total = 0;
  int bad   = 0;

  // Expected contents of the MEM/WB register
  logic        exp_rw;
  logic [1:0]  exp_rs;
  logic [31:0] exp_alu, exp_rdata, exp_pc;
  logic [4:0]  exp_rd;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_rw = 1'b0; exp_rs = 2'b00; exp_alu = '0; exp_rdata = '0; exp_pc = '0; exp_rd = '0;
  endtask

  task automatic check_w(input string tag);
    check_eq({tag, ".RegWriteW"},  32'(RegWriteW),  32'(exp_rw));
    check_eq({tag, ".ResultSrcW"}, 32'(ResultSrcW), 32'(exp_rs));
    check_eq({tag, ".ALUResultW"}, ALUResultW,      exp_alu);
    check_eq({tag, ".ReadDataW"},  ReadDataW,       exp_rdata);
    check_eq({tag, ".RdW"},        32'(RdW),        32'(exp_rd));
    check_eq({tag, ".PCPlus4W"},   PCPlus4W,        exp_pc);
  endtask

  // One instruction through the stage; waits = cycles before mem_ack.
  task automatic run_instr(input string tag, input logic rw, input logic [1:0] rs, input logic mw,
                           input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] rdata,
                           input int waits);
    logic        is_load, access, mis, req;
    logic [3:0]  strb;
    logic [31:0] wdat, ld, b, h;
    int unsigned a;
    a       = 32'(addr[1:0]);
    is_load = (rs == 2'b01);
    access  = mw | is_load;
    mis     = 1'b0;
`ifdef MISALIGN_TRAP_EN
    if (access && (op == 3'd1 || op == 3'd5) && (a % 2 == 1)) mis = 1'b1;
    if (access && op == 3'd2 && a != 0) mis = 1'b1;
`endif
    req = access & ~mis;
    case (op)
      3'd0:    begin strb = 4'(1 << a);           wdat = (wd & 32'hFF) * 32'h01010101; end
      3'd1:    begin strb = 4'(3 << (2 * (a / 2))); wdat = (wd & 32'hFFFF) * 32'h00010001; end
      default: begin strb = 4'hF;                 wdat = wd; end
    endcase
    b = (rdata >> (8 * a)) & 32'hFF;
    h = (rdata >> (16 * (a / 2))) & 32'hFFFF;
    case (op)
      3'd0:    ld = (b >= 32'h80)   ? (b | 32'hFFFFFF00) : b;
      3'd4:    ld = b;
      3'd1:    ld = (h >= 32'h8000) ? (h | 32'hFFFF0000) : h;
      3'd5:    ld = h;
      default: ld = rdata;
    endcase

    RegWriteM = rw; ResultSrcM = rs; MemWriteM = mw; MemoryOpM = op; ALUResultM = addr;
    WriteDataM = wd; RdM = rd; PCPlus4M = pc; mem_rdata = rdata;
    mem_ack = (waits == 0);
    #1;
    check_eq({tag, ".mem_req"}, 32'(mem_req), 32'(req));
    check_eq({tag, ".StallM"},  32'(StallM),  32'(req && waits > 0));
    if (req) begin
      check_eq({tag, ".mem_addr"}, mem_addr, addr & 32'hFFFFFFFC);
      check_eq({tag, ".mem_we"},   32'(mem_we), 32'(mw));
      check_eq({tag, ".mem_wstrb"}, 32'(mem_wstrb), mw ? 32'(strb) : 32'h0);
      if (mw) check_eq({tag, ".mem_wdata"}, mem_wdata, wdat);
    end
    if (req) begin
      for (int i = 0; i < waits; i++) begin
        @(posedge clk); #1;
        check_eq({tag, ".bubble.RegWriteW"}, 32'(RegWriteW), 32'h0);
        check_eq({tag, ".bubble.RdW"},       32'(RdW),       32'h0);
        check_eq({tag, ".bubble.ALUResultW"}, ALUResultW, exp_alu);
        check_eq({tag, ".bubble.PCPlus4W"},   PCPlus4W,   exp_pc);
        if (i == waits - 1) mem_ack = 1'b1;
        #1;
        check_eq({tag, ".wait.mem_req"}, 32'(mem_req), 32'h1);
        check_eq({tag, ".wait.StallM"},  32'(StallM),  32'(i < waits - 1));
      end
    end
    @(posedge clk); #1;
    exp_rw = rw & ~mis; exp_rs = rs; exp_alu = addr; exp_rd = rd; exp_pc = pc;
    exp_rdata = (is_load && !mis) ? ld : 32'h0;
    check_w(tag);
`ifdef MISALIGN_TRAP_EN
    check_eq({tag, ".MisalignW"}, 32'(MisalignW), 32'(mis));
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    RegWriteM = 1'b0; ResultSrcM = 2'b00; MemWriteM = 1'b0; MemoryOpM = 3'd0;
    ALUResultM = '0; WriteDataM = '0; RdM = '0; PCPlus4M = '0; mem_ack = 1'b0; mem_rdata = '0;
    model_reset();
    #2;
    check_w("reset");
    check_eq("reset.mem_req", 32'(mem_req), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed cases from the block's known scenarios
    run_instr("sw",   1'b0, 2'b00, 1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 5'd0, 32'h4, 32'h0, 0);
    run_instr("sb",   1'b0, 2'b00, 1'b1, 3'd0, 32'h103, 32'h123456A5, 5'd0, 32'h8, 32'h0, 2);
    run_instr("sh",   1'b0, 2'b00, 1'b1, 3'd1, 32'h102, 32'h0000BEEF, 5'd0, 32'hC, 32'h0, 1);
    run_instr("lb",   1'b1, 2'b01, 1'b0, 3'd0, 32'h102, 32'h0, 5'd1, 32'h10, 32'h0080FF00, 0);
    run_instr("lbu",  1'b1, 2'b01, 1'b0, 3'd4, 32'h102, 32'h0, 5'd2, 32'h14, 32'h0080FF00, 1);
    run_instr("lhu",  1'b1, 2'b01, 1'b0, 3'd5, 32'h102, 32'h0, 5'd3, 32'h18, 32'h0080FF00, 0);
    run_instr("lh",   1'b1, 2'b01, 1'b0, 3'd1, 32'h100, 32'h0, 5'd4, 32'h1C, 32'h0080FF00, 3);
    run_instr("alu",  1'b1, 2'b00, 1'b0, 3'd0, 32'h7,   32'h0, 5'd5, 32'h20, 32'h0, 0);
    run_instr("jal",  1'b1, 2'b10, 1'b0, 3'd0, 32'h55,  32'h0, 5'd1, 32'h24, 32'h0, 0);
    run_instr("lwmis", 1'b1, 2'b01, 1'b0, 3'd2, 32'h101, 32'h0, 5'd6, 32'h28, 32'hCAFEF00D, 0);

    // Asynchronous reset while waiting for an acknowledge
    RegWriteM = 1'b1; ResultSrcM = 2'b01; MemWriteM = 1'b0; MemoryOpM = 3'd2;
    ALUResultM = 32'h200; RdM = 5'd3; PCPlus4M = 32'h40; mem_ack = 1'b0;
    @(posedge clk); #1;
    check_eq("rstwait.StallM", 32'(StallM), 32'h1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("rstwait.mem_req", 32'(mem_req), 32'h0);
    check_eq("rstwait.StallM0", 32'(StallM), 32'h0);
    check_w("rstwait");
    @(posedge clk); #1 rst_n = 1'b1;
    run_instr("lw_after_rst", 1'b1, 2'b01, 1'b0, 3'd2, 32'h300, 32'h0, 5'd9, 32'h44, 32'h13572468, 1);

    // Randomized instruction mix
    for (int n = 0; n < 300; n++) begin
      int unsigned kind;
      logic [2:0]  op;
      logic [2:0]  lops [5];
      lops[0] = 3'd0; lops[1] = 3'd1; lops[2] = 3'd2; lops[3] = 3'd4; lops[4] = 3'd5;
      kind = $urandom_range(3);
      case (kind)
        0: run_instr("rnd.alu", 1'($urandom), 2'b00, 1'b0, 3'($urandom), $urandom, $urandom,
                     5'($urandom), $urandom, $urandom, 0);
        1: begin
          op = lops[$urandom_range(4)];
          run_instr("rnd.load", 1'b1, 2'b01, 1'b0, op, $urandom, $urandom,
                    5'($urandom), $urandom, $urandom, int'($urandom_range(3)));
        end
        2: begin
          op = 3'($urandom_range(2));
          run_instr("rnd.store", 1'b0, 2'b00, 1'b1, op, $urandom, $urandom,
                    5'($urandom), $urandom, $urandom, int'($urandom_range(3)));
        end
        default: run_instr("rnd.link", 1'b1, 2'b10, 1'b0, 3'($urandom), $urandom, $urandom,
                           5'($urandom), $urandom, $urandom, 0);
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
